vec_cache_rd_resp_collector: RTL and testbench
==============================================

# vec_cache_rd_resp_collector

West-edge receiver for the bank-row data mesh: it consumes the 8 data lanes leaving a row of `vec_cache_sram_bank` instances. It reassembles multi-beat read responses per transaction ID and returns each completed line to the requester through a valid/ready port. The mesh has no backpressure, so the block accepts every beat on every cycle. It is the sink end of the read path whose source is the west read-command injector.

## Interface
Parameters:
- `LANES`, 8: data lanes from the mesh.
- `DATA_W`, 128: bits per beat.
- `ID_W`, 3: transaction ID width. Slot count is `2**ID_W`.
- `BEATS`, 4: beats per line, power of 2. `BEAT_W = $clog2(BEATS)`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `alloc_vld`, in, 1: requester opens a transaction.
- `alloc_id`, in, ID_W: ID being opened.
- `lane_vld`, in, LANES: beat valid per lane.
- `lane_id`, in, LANES×ID_W: transaction ID of each lane's beat.
- `lane_beat`, in, LANES×BEAT_W: beat index within the line.
- `lane_data`, in, LANES×DATA_W: beat payload.
- `resp_vld`, out, 1: a completed line is presented.
- `resp_rdy`, in, 1: requester accepts the line.
- `resp_id`, out, ID_W: ID of the presented line.
- `resp_data`, out, BEATS×DATA_W: line data, with beat k at bits [k*DATA_W +: DATA_W].
- `outstanding`, out, ID_W+1: count of slots not in IDLE.
- `err_alloc`, out, 1: sticky. Allocation made to a busy slot.
- `err_unexp`, out, 1: sticky. Beat arrived for an IDLE or DONE slot.
- `err_dup`, out, 1: sticky. Duplicate beat for the same slot and index.

## Operation
- Each slot has a state in {IDLE, FILL, DONE}, a BEATS-bit mask, and BEATS×DATA_W of storage.
- IDLE→FILL when `alloc_vld`, provided the slot is IDLE or is released by a resp handshake in the same cycle. In both cases the mask clears.
- An alloc to a slot that is in FILL, or in DONE without a same-cycle release, sets `err_alloc`. The alloc is ignored.
- Beat acceptance, per lane with `lane_vld`:
  - Slot in FILL and mask bit clear: write the data and set the mask bit.
  - Slot in IDLE or DONE: drop the beat and set `err_unexp`.
  - Mask bit already set, or a lower-index lane in the same cycle targets the same (id, beat): drop the beat and set `err_dup`. The lowest-index lane wins.
- Any number of lanes may write distinct (id, beat) pairs in one cycle, including several beats of one slot.
- FILL→DONE when the mask with the bits accepted this cycle is all ones.
- Output selection:
  - Round-robin over DONE slots, starting at `rr_ptr`.
  - The selection is locked while `resp_vld & !resp_rdy`. `resp_id` and `resp_data` hold stable until the handshake.
- On handshake:
  - The slot goes DONE→IDLE, unless it is re-allocated in the same cycle, in which case it goes to FILL.
  - `rr_ptr` becomes `resp_id+1`, modulo slot count.
- `outstanding` equals the number of FILL slots plus DONE slots, registered.
- Error flags are sticky until reset.

## Timing
- Reset values:
  - All slots IDLE, all masks 0, storage 0.
  - `rr_ptr`=0, lock cleared.
  - `resp_vld`=0, `resp_id`=0, `resp_data`=0, `outstanding`=0, all error flags 0.
- Latency:
  - A beat that completes a slot, sampled at edge t, gives `resp_vld`=1 from edge t (visible in cycle t+1).
  - Alloc at edge t means beats are accepted from edge t+1.
  - A beat in the same cycle as the slot's alloc counts as unexpected.
- `resp_*` is driven from registers and storage only. There is no combinational path from `lane_*` or `resp_rdy`.
- Sustained throughput: one line per cycle when `resp_rdy`=1 and multiple slots are DONE.
- Reset asserted mid-transaction discards all slots and clears the outputs asynchronously.

## Test plan
- Single line: alloc id 2, then 4 beats on lanes 0..3 in one cycle (data 0xA0..0xA3) → next cycle `resp_vld`=1, `resp_id`=2, `resp_data`={A3,A2,A1,A0}. With `resp_rdy`=1, `outstanding` goes 1→0.
- Scattered beats: id 5, with beats 3,1,0,2 spread over 4 cycles on varied lanes → `resp_vld` rises exactly one cycle after the last beat, with the data correctly ordered.
- Backpressure and RR:
  - Stimulus: ids 1, 4, 6 all DONE, `rr_ptr`=0, `resp_rdy` low for 3 cycles and id 0 completing meanwhile.
  - Required: `resp_id` held at 1 throughout, then the order 1, 4, 6, 0 with one line per cycle.
- Errors:
  - A beat to IDLE id 3 sets `err_unexp`.
  - The same (id 5, beat 0) on lanes 2 and 6 in one cycle: lane 2 data is stored and `err_dup` is set.
  - Alloc of a FILL id sets `err_alloc`, and the slot is unchanged.
- Release and realloc: a handshake on id 7 together with alloc id 7 in the same cycle → slot 7 in FILL with an empty mask, no error, `outstanding` unchanged.
- Reset with 3 slots in FILL → all outputs 0. A subsequent full fill of id 0 works normally.

Source files
------------

// File: rtl/vec_cache_rd_resp_collector.sv
// Read-response collector: reassembles multi-beat lines per transaction ID from the
// bank-row mesh lanes and returns completed lines round-robin over a valid/ready port.
module vec_cache_rd_resp_collector #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned BEATS  = 4,
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned NSLOT  = 2 ** ID_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_vld,
  input  logic [ID_W-1:0]           alloc_id,
  input  logic [LANES-1:0]          lane_vld,
  input  logic [LANES*ID_W-1:0]     lane_id,
  input  logic [LANES*BEAT_W-1:0]   lane_beat,
  input  logic [LANES*DATA_W-1:0]   lane_data,
  output logic                      resp_vld,
  input  logic                      resp_rdy,
  output logic [ID_W-1:0]           resp_id,
  output logic [BEATS*DATA_W-1:0]   resp_data,
  output logic [ID_W:0]             outstanding,
  output logic                      err_alloc,
  output logic                      err_unexp,
  output logic                      err_dup
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} slot_state_e;

  slot_state_e               state_q [NSLOT];
  slot_state_e               state_d [NSLOT];
  logic [BEATS-1:0]          mask_q  [NSLOT];
  logic [BEATS-1:0]          mask_d  [NSLOT];
  logic [BEATS-1:0]          acc     [NSLOT];
  logic [BEATS*DATA_W-1:0]   data_q  [NSLOT];
  logic [BEATS*DATA_W-1:0]   data_d  [NSLOT];

  logic [ID_W-1:0]  rr_q, rr_d;
  logic             resp_vld_q, resp_vld_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [ID_W:0]    outstanding_q, outstanding_d;
  logic             err_alloc_q, err_unexp_q, err_dup_q;
  logic             set_alloc, set_unexp, set_dup;

  logic             hs, lock, alloc_ok, dup_lower, found;
  logic [ID_W-1:0]  cur_id, idx, sel;
  logic [BEAT_W-1:0] cur_beat;
  logic [NSLOT-1:0] done_d;

  assign hs   = resp_vld_q & resp_rdy;
  assign lock = resp_vld_q & ~resp_rdy;

  // Slot bookkeeping: alloc, beat acceptance, completion and release.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    data_d    = data_q;
    set_alloc = 1'b0;
    set_unexp = 1'b0;
    set_dup   = 1'b0;
    alloc_ok  = 1'b0;
    dup_lower = 1'b0;
    cur_id    = '0;
    cur_beat  = '0;
    for (int s = 0; s < NSLOT; s++) acc[s] = '0;

    if (alloc_vld) begin
      if (state_q[alloc_id] == StIdle ||
          (state_q[alloc_id] == StDone && hs && resp_id_q == alloc_id)) begin
        alloc_ok = 1'b1;
      end else begin
        set_alloc = 1'b1;
      end
    end

    for (int l = 0; l < LANES; l++) begin
      if (lane_vld[l]) begin
        cur_id    = lane_id[l*ID_W +: ID_W];
        cur_beat  = lane_beat[l*BEAT_W +: BEAT_W];
        dup_lower = 1'b0;
        for (int j = 0; j < l; j++) begin
          if (lane_vld[j] && lane_id[j*ID_W +: ID_W] == cur_id &&
              lane_beat[j*BEAT_W +: BEAT_W] == cur_beat) begin
            dup_lower = 1'b1;
          end
        end
        if (state_q[cur_id] != StFill) begin
          set_unexp = 1'b1;
        end else if (mask_q[cur_id][cur_beat] || dup_lower) begin
          set_dup = 1'b1;
        end else begin
          acc[cur_id][cur_beat] = 1'b1;
          data_d[cur_id][cur_beat*DATA_W +: DATA_W] = lane_data[l*DATA_W +: DATA_W];
        end
      end
    end

    for (int s = 0; s < NSLOT; s++) begin
      if (hs && resp_id_q == ID_W'(s)) begin
        state_d[s] = (alloc_ok && alloc_id == ID_W'(s)) ? StFill : StIdle;
        mask_d[s]  = '0;
      end else if (alloc_ok && alloc_id == ID_W'(s)) begin
        state_d[s] = StFill;
        mask_d[s]  = '0;
      end else if (state_q[s] == StFill) begin
        mask_d[s] = mask_q[s] | acc[s];
        if (&mask_d[s]) state_d[s] = StDone;
      end
    end
  end

  // Round-robin pick over next-cycle DONE slots, held while the requester stalls.
  always_comb begin
    rr_d          = hs ? resp_id_q + 1'b1 : rr_q;
    found         = 1'b0;
    sel           = resp_id_q;
    idx           = '0;
    outstanding_d = '0;
    for (int s = 0; s < NSLOT; s++) begin
      done_d[s] = (state_d[s] == StDone);
      if (state_d[s] != StIdle) outstanding_d = outstanding_d + 1'b1;
    end
    for (int i = 0; i < NSLOT; i++) begin
      idx = rr_d + ID_W'(i);
      if (!found && done_d[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    resp_vld_d = lock ? 1'b1 : found;
    resp_id_d  = lock ? resp_id_q : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSLOT; s++) begin
        state_q[s] <= StIdle;
        mask_q[s]  <= '0;
        data_q[s]  <= '0;
      end
      rr_q          <= '0;
      resp_vld_q    <= 1'b0;
      resp_id_q     <= '0;
      outstanding_q <= '0;
      err_alloc_q   <= 1'b0;
      err_unexp_q   <= 1'b0;
      err_dup_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      data_q        <= data_d;
      rr_q          <= rr_d;
      resp_vld_q    <= resp_vld_d;
      resp_id_q     <= resp_id_d;
      outstanding_q <= outstanding_d;
      err_alloc_q   <= err_alloc_q | set_alloc;
      err_unexp_q   <= err_unexp_q | set_unexp;
      err_dup_q     <= err_dup_q | set_dup;
    end
  end

  assign resp_vld    = resp_vld_q;
  assign resp_id     = resp_id_q;
  // A presented slot is DONE, so its storage cannot change until the handshake.
  assign resp_data   = data_q[resp_id_q];
  assign outstanding = outstanding_q;
  assign err_alloc   = err_alloc_q;
  assign err_unexp   = err_unexp_q;
  assign err_dup     = err_dup_q;

endmodule

// File: tb/tb_vec_cache_rd_resp_collector.sv
// Directed self-checking bench for vec_cache_rd_resp_collector.
module tb_vec_cache_rd_resp_collector;

  localparam int unsigned LANES  = 8;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     alloc_vld;
  logic [ID_W-1:0]          alloc_id;
  logic [LANES-1:0]         lane_vld;
  logic [LANES*ID_W-1:0]    lane_id;
  logic [LANES*BEAT_W-1:0]  lane_beat;
  logic [LANES*DATA_W-1:0]  lane_data;
  logic                     resp_vld;
  logic                     resp_rdy;
  logic [ID_W-1:0]          resp_id;
  logic [BEATS*DATA_W-1:0]  resp_data;
  logic [ID_W:0]            outstanding;
  logic                     err_alloc, err_unexp, err_dup;

  int checks = 0;
  int failures = 0;

  vec_cache_rd_resp_collector #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ID_W  (ID_W),
    .BEATS (BEATS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_vld  (alloc_vld),
    .alloc_id   (alloc_id),
    .lane_vld   (lane_vld),
    .lane_id    (lane_id),
    .lane_beat  (lane_beat),
    .lane_data  (lane_data),
    .resp_vld   (resp_vld),
    .resp_rdy   (resp_rdy),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .outstanding(outstanding),
    .err_alloc  (err_alloc),
    .err_unexp  (err_unexp),
    .err_dup    (err_dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    lane_vld  = '0;
    lane_id   = '0;
    lane_beat = '0;
    lane_data = '0;
  endtask

  task automatic set_beat(input int lane, input int id, input int beat, input logic [127:0] d);
    lane_vld[lane]                   = 1'b1;
    lane_id[lane*ID_W +: ID_W]       = ID_W'(id);
    lane_beat[lane*BEAT_W +: BEAT_W] = BEAT_W'(beat);
    lane_data[lane*DATA_W +: DATA_W] = d;
  endtask

  // Four beats of one line on lanes base..base+3, data = base_d + beat.
  task automatic set_line(input int base, input int id, input logic [127:0] base_d);
    for (int k = 0; k < 4; k++) set_beat(base + k, id, k, base_d + 128'(k));
  endtask

  task automatic do_alloc(input int id);
    alloc_vld = 1'b1;
    alloc_id  = ID_W'(id);
    tick();
    alloc_vld = 1'b0;
  endtask

  function automatic logic [511:0] line_of(input logic [127:0] base_d);
    return {base_d + 128'd3, base_d + 128'd2, base_d + 128'd1, base_d};
  endfunction

  initial begin
    rst_n     = 1'b0;
    alloc_vld = 1'b0;
    alloc_id  = '0;
    resp_rdy  = 1'b0;
    clear_lanes();
    #1;
    check("rst_vld", 512'(resp_vld), 512'd0);
    check("rst_id", 512'(resp_id), 512'd0);
    check("rst_data", resp_data, 512'd0);
    check("rst_out", 512'(outstanding), 512'd0);
    check("rst_err", 512'({err_alloc, err_unexp, err_dup}), 512'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single line, id 2, all beats in one cycle.
    do_alloc(2);
    check("t1_out_alloc", 512'(outstanding), 512'd1);
    check("t1_vld_pre", 512'(resp_vld), 512'd0);
    set_line(0, 2, 128'hA0);
    tick();
    clear_lanes();
    check("t1_vld", 512'(resp_vld), 512'd1);
    check("t1_id", 512'(resp_id), 512'd2);
    check("t1_data", resp_data, line_of(128'hA0));
    check("t1_out_done", 512'(outstanding), 512'd1);
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    check("t1_vld_hs", 512'(resp_vld), 512'd0);
    check("t1_out_hs", 512'(outstanding), 512'd0);

    // Scattered beats for id 5.
    do_alloc(5);
    set_beat(4, 5, 3, 128'hB3); tick(); clear_lanes();
    set_beat(7, 5, 1, 128'hB1); tick(); clear_lanes();
    set_beat(0, 5, 0, 128'hB0); tick(); clear_lanes();
    check("t2_vld_pre", 512'(resp_vld), 512'd0);
    set_beat(2, 5, 2, 128'hB2); tick(); clear_lanes();
    check("t2_vld", 512'(resp_vld), 512'd1);
    check("t2_id", 512'(resp_id), 512'd5);
    check("t2_data", resp_data, line_of(128'hB0));
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    check("t2_err_none", 512'({err_alloc, err_unexp, err_dup}), 512'd0);

    // Release and re-allocate id 7 in the same cycle.
    do_alloc(7);
    set_line(4, 7, 128'h70);
    tick();
    clear_lanes();
    check("t3_vld", 512'(resp_vld), 512'd1);
    check("t3_id", 512'(resp_id), 512'd7);
    resp_rdy  = 1'b1;
    alloc_vld = 1'b1;
    alloc_id  = 3'd7;
    tick();
    resp_rdy  = 1'b0;
    alloc_vld = 1'b0;
    check("t3_vld_hs", 512'(resp_vld), 512'd0);
    check("t3_out", 512'(outstanding), 512'd1);
    check("t3_err_alloc", 512'(err_alloc), 512'd0);
    set_beat(1, 7, 0, 128'h90); tick(); clear_lanes();
    check("t3_mask_empty", 512'({err_dup, err_unexp, resp_vld}), 512'd0);
    for (int k = 1; k < 4; k++) set_beat(k, 7, k, 128'h90 + 128'(k));
    tick();
    clear_lanes();
    check("t3_refill", resp_data, line_of(128'h90));
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;

    // Errors: unexpected, duplicate, bad alloc.
    set_beat(1, 3, 0, 128'hEE); tick(); clear_lanes();
    check("t4_unexp", 512'({err_alloc, err_unexp, err_dup}), 512'b010);
    do_alloc(5);
    set_beat(2, 5, 0, 128'hC2);
    set_beat(6, 5, 0, 128'hC6);
    tick();
    clear_lanes();
    check("t4_dup", 512'(err_dup), 512'd1);
    do_alloc(5);
    check("t4_alloc", 512'(err_alloc), 512'd1);
    check("t4_out", 512'(outstanding), 512'd1);
    for (int k = 1; k < 4; k++) set_beat(k - 1, 5, k, 128'hD0 + 128'(k));
    tick();
    clear_lanes();
    check("t4_vld", 512'(resp_vld), 512'd1);
    check("t4_data", resp_data, {128'hD3, 128'hD2, 128'hD1, 128'hC2});

    // Reset with three slots in FILL (plus the pending DONE slot).
    do_alloc(1);
    do_alloc(4);
    do_alloc(6);
    check("t5_out_pre", 512'(outstanding), 512'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_vld", 512'(resp_vld), 512'd0);
    check("t5_rst_data", resp_data, 512'd0);
    check("t5_rst_out", 512'(outstanding), 512'd0);
    check("t5_rst_err", 512'({err_alloc, err_unexp, err_dup}), 512'd0);
    tick();
    rst_n = 1'b1;

    // Backpressure and round-robin: 1,4,6 DONE, then 0 completes while stalled.
    do_alloc(1);
    do_alloc(4);
    do_alloc(6);
    do_alloc(0);
    set_line(0, 1, 128'h10);
    set_line(4, 4, 128'h40);
    tick();
    clear_lanes();
    check("t6_id_a", 512'({resp_vld, resp_id}), {508'd0, 1'b1, 3'd1});
    set_line(0, 6, 128'h60);
    tick();
    clear_lanes();
    check("t6_id_b", 512'({resp_vld, resp_id}), {508'd0, 1'b1, 3'd1});
    set_line(2, 0, 128'h00);
    tick();
    clear_lanes();
    check("t6_id_c", 512'({resp_vld, resp_id}), {508'd0, 1'b1, 3'd1});
    check("t6_data_1", resp_data, line_of(128'h10));
    check("t6_out", 512'(outstanding), 512'd4);
    resp_rdy = 1'b1;
    tick();
    check("t6_order_4", 512'({resp_vld, resp_id}), {508'd0, 1'b1, 3'd4});
    tick();
    check("t6_order_6", 512'({resp_vld, resp_id}), {508'd0, 1'b1, 3'd6});
    check("t6_data_6", resp_data, line_of(128'h60));
    tick();
    check("t6_order_0", 512'({resp_vld, resp_id}), {508'd0, 1'b1, 3'd0});
    check("t6_data_0", resp_data, line_of(128'h00));
    tick();
    resp_rdy = 1'b0;
    check("t6_empty", 512'({resp_vld, outstanding}), 512'd0);
    check("t6_err_none", 512'({err_alloc, err_unexp, err_dup}), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
